// File: rtl/os_pulse_pkg.sv
// rtl/os_pulse_pkg.sv - shared state type and default sizing for the pulse measurement block
package os_pulse_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/os_edge_det.sv
// rtl/os_edge_det.sv - gated rising-edge detector; prev resets high so a level held through reset is not an edge
module os_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic en,
  output logic rise
);

  logic prev;

  // Track the previous level every cycle, independent of the enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b1;
    end else begin
      prev <= in;
    end
  end

  assign rise = en & in & ~prev;

endmodule

// File: rtl/os_pulse_meas.sv
// rtl/os_pulse_meas.sv - trigger-to-pulse delay and pulse width measurement; optional retrigger via OS_PULSE_MEAS_RETRIG_EN
module os_pulse_meas
  import os_pulse_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             trig_en,
  input  logic             pulse_in,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] delay_cnt,
  output logic [CNT_W-1:0] width_cnt,
  output logic             width_sat,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] width;
  logic             sat;
  logic             rise;

  state_t           start_state;
  logic [CNT_W-1:0] start_delay;
  logic [CNT_W-1:0] start_width;

  os_edge_det u_edge (
    .clk  (clk),
    .reset(reset),
    .in   (trig),
    .en   (trig_en),
    .rise (rise)
  );

  // Where a new measurement lands depends on whether the pulse is already high at the edge.
  always_comb begin
    start_state = WAIT;
    start_delay = CNT_ONE;
    start_width = '0;
    if (pulse_in) begin
      start_state = HIGH;
      start_delay = '0;
      start_width = CNT_ONE;
    end
  end

  // Measurement FSM with registered result and strobe outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      delay       <= '0;
      width       <= '0;
      sat         <= 1'b0;
      delay_cnt   <= '0;
      width_cnt   <= '0;
      width_sat   <= 1'b0;
      valid       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      valid       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= start_state;
            delay <= start_delay;
            width <= start_width;
            sat   <= 1'b0;
          end
        end
        WAIT: begin
`ifdef OS_PULSE_MEAS_RETRIG_EN
          if (rise) begin
            state <= start_state;
            delay <= start_delay;
            width <= start_width;
            sat   <= 1'b0;
          end else
`endif
          if (pulse_in) begin
            state <= HIGH;
            width <= CNT_ONE;
            sat   <= 1'b0;
          end else if (delay == TIMEOUT_V) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            delay <= delay + CNT_ONE;
          end
        end
        HIGH: begin
          if (!pulse_in) begin
            delay_cnt <= delay;
            width_cnt <= width;
            width_sat <= sat;
            valid     <= 1'b1;
            state     <= IDLE;
`ifdef OS_PULSE_MEAS_RETRIG_EN
            // A coinciding edge both completes the old measurement and starts a new one.
            if (rise) begin
              state <= start_state;
              delay <= start_delay;
              width <= start_width;
              sat   <= 1'b0;
            end
`endif
          end
`ifdef OS_PULSE_MEAS_RETRIG_EN
          else if (rise) begin
            state <= start_state;
            delay <= start_delay;
            width <= start_width;
            sat   <= 1'b0;
          end
`endif
          else if (width == CNT_MAX) begin
            sat <= 1'b1;
          end else begin
            width <= width + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_os_pulse_meas.sv
// tb/tb_os_pulse_meas.sv - directed self-checking bench for os_pulse_meas (CNT_W=4, TIMEOUT=10)
module tb_os_pulse_meas;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 10;

`ifdef OS_PULSE_MEAS_RETRIG_EN
  localparam int EXP_RETRIG_DELAY = 3;
`else
  localparam int EXP_RETRIG_DELAY = 5;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             trig;
  logic             trig_en;
  logic             pulse_in;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] delay_cnt;
  logic [CNT_W-1:0] width_cnt;
  logic             width_sat;
  logic             timeout_err;

  int n_pass  = 0;
  int n_total = 0;
  int bad;
  int nval;

  os_pulse_meas #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .trig       (trig),
    .trig_en    (trig_en),
    .pulse_in   (pulse_in),
    .busy       (busy),
    .valid      (valid),
    .delay_cnt  (delay_cnt),
    .width_cnt  (width_cnt),
    .width_sat  (width_sat),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    reset    = 1'b1;
    trig     = 1'b1;
    trig_en  = 1'b1;
    pulse_in = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_delay", 32'(delay_cnt), 0);
    chk("rst_width", 32'(width_cnt), 0);
    chk("rst_sat", 32'(width_sat), 0);
    chk("rst_timeout", 32'(timeout_err), 0);

    // trig held high across reset release is not an edge
    reset = 1'b0;
    bad = 0;
    repeat (3) begin
      step();
      if (busy) bad++;
    end
    chk("no_edge_after_reset", 32'(bad), 0);
    trig = 1'b0;
    step();

    // edge at t, pulse high t+3..t+4 -> valid t+6, delay 3, width 2
    trig = 1'b1;
    step();
    chk("basic_busy", 32'(busy), 1);
    trig = 1'b0;
    step();
    step();
    pulse_in = 1'b1;
    step();
    step();
    pulse_in = 1'b0;
    chk("basic_valid_early", 32'(valid), 0);
    step();
    chk("basic_valid", 32'(valid), 1);
    chk("basic_delay", 32'(delay_cnt), 3);
    chk("basic_width", 32'(width_cnt), 2);
    chk("basic_sat", 32'(width_sat), 0);
    chk("basic_busy_done", 32'(busy), 0);
    step();
    chk("basic_valid_one_cycle", 32'(valid), 0);
    chk("basic_delay_hold", 32'(delay_cnt), 3);

    // pulse already high at the edge -> delay 0, width 1, valid 2 cycles later
    trig = 1'b1;
    pulse_in = 1'b1;
    step();
    trig = 1'b0;
    pulse_in = 1'b0;
    chk("imm_valid_early", 32'(valid), 0);
    step();
    chk("imm_valid", 32'(valid), 1);
    chk("imm_delay", 32'(delay_cnt), 0);
    chk("imm_width", 32'(width_cnt), 1);

    // no pulse -> timeout_err 11 cycles after the edge, no valid
    trig = 1'b1;
    step();
    trig = 1'b0;
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      if (timeout_err || valid || !busy) bad++;
      step();
    end
    chk("to_quiet_before", 32'(bad), 0);
    chk("to_strobe", 32'(timeout_err), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_no_valid", 32'(valid), 0);
    chk("to_delay_hold", 32'(delay_cnt), 0);
    chk("to_width_hold", 32'(width_cnt), 1);
    step();
    chk("to_one_cycle", 32'(timeout_err), 0);

    // pulse arrives exactly at delay == TIMEOUT -> measured, not aborted
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (9) step();
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
    chk("edge_to_none", 32'(timeout_err), 0);
    chk("edge_to_busy", 32'(busy), 1);
    step();
    chk("edge_to_valid", 32'(valid), 1);
    chk("edge_to_delay", 32'(delay_cnt), 10);
    chk("edge_to_width", 32'(width_cnt), 1);

    // second edge at t+2 in WAIT, 20-cycle pulse from t+5 -> width saturates
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
    step();
    pulse_in = 1'b1;
    nval = 0;
    repeat (20) begin
      if (valid) nval++;
      step();
    end
    pulse_in = 1'b0;
    chk("sat_no_early_valid", 32'(nval), 0);
    step();
    chk("sat_valid", 32'(valid), 1);
    chk("sat_delay", 32'(delay_cnt), EXP_RETRIG_DELAY);
    chk("sat_width", 32'(width_cnt), 15);
    chk("sat_flag", 32'(width_sat), 1);
    step();
    chk("sat_valid_one_cycle", 32'(valid), 0);

    // trig_en low suppresses an idle edge
    trig_en = 1'b0;
    trig = 1'b1;
    step();
    chk("en_off_no_start", 32'(busy), 0);
    trig = 1'b0;
    step();
    // dropping trig_en mid-measurement does not abort it
    trig_en = 1'b1;
    trig = 1'b1;
    pulse_in = 1'b1;
    step();
    trig = 1'b0;
    trig_en = 1'b0;
    step();
    pulse_in = 1'b0;
    step();
    chk("en_off_valid", 32'(valid), 1);
    chk("en_off_delay", 32'(delay_cnt), 0);
    chk("en_off_width", 32'(width_cnt), 2);
    chk("en_off_sat", 32'(width_sat), 0);
    trig_en = 1'b1;

    // reset during HIGH discards the measurement
    trig = 1'b1;
    pulse_in = 1'b1;
    step();
    trig = 1'b0;
    step();
    step();
    reset = 1'b1;
    trig = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_timeout", 32'(timeout_err), 0);
    chk("mid_rst_delay", 32'(delay_cnt), 0);
    chk("mid_rst_width", 32'(width_cnt), 0);
    chk("mid_rst_sat", 32'(width_sat), 0);
    step();
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      step();
      if (busy || valid || timeout_err) bad++;
    end
    chk("mid_rst_no_restart", 32'(bad), 0);
    trig = 1'b0;
    pulse_in = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
